// File: rtl/fe_inv_seq_pkg.sv
// Shared curve package: field width, modulus, element type, FSM states and a
// behavioural reference for the modular division b * a^-1 mod P.
package fe_inv_seq_pkg;

  localparam int unsigned DAT_BITS = 256;

  typedef logic [DAT_BITS-1:0] fe_t;

  // bn128 base field modulus
  localparam fe_t P = 256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

  localparam int unsigned MAX_ITER = 4 * DAT_BITS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Binary extended-Euclid division; returns 0 for a==0, a>=P or iteration overrun.
  function automatic fe_t fe_inv(input fe_t a, input fe_t b);
    fe_t u;
    fe_t v;
    fe_t x1;
    fe_t x2;
    logic [DAT_BITS:0] s;
    if (a == '0 || a >= P) return '0;
    u  = a;
    v  = P;
    x1 = b;
    x2 = '0;
    for (int unsigned i = 0; i <= MAX_ITER; i++) begin
      if (u == fe_t'(1)) return x1;
      if (v == fe_t'(1)) return x2;
      if (i == MAX_ITER) break;
      if (!u[0]) begin
        u  = u >> 1;
        s  = {1'b0, x1} + (x1[0] ? {1'b0, P} : '0);
        x1 = fe_t'(s >> 1);
      end else if (!v[0]) begin
        v  = v >> 1;
        s  = {1'b0, x2} + (x2[0] ? {1'b0, P} : '0);
        x2 = fe_t'(s >> 1);
      end else if (u >= v) begin
        u  = u - v;
        x1 = x1 - x2 + ((x1 < x2) ? P : '0);
      end else begin
        v  = v - u;
        x2 = x2 - x1 + ((x2 < x1) ? P : '0);
      end
    end
    return '0;
  endfunction

endpackage

// File: rtl/fe_half_sub.sv
// Mod-P datapath for one x register: either halve x, or subtract y from x,
// keeping the result in [0, P).
module fe_half_sub #(
  parameter int unsigned         DAT_BITS = fe_inv_seq_pkg::DAT_BITS,
  parameter logic [DAT_BITS-1:0] P        = DAT_BITS'(fe_inv_seq_pkg::P)
) (
  input  logic [DAT_BITS-1:0] x,
  input  logic [DAT_BITS-1:0] y,
  input  logic                sub,
  output logic [DAT_BITS-1:0] res_c
);

  logic [DAT_BITS:0]   sum;
  logic [DAT_BITS-1:0] half;
  logic [DAT_BITS-1:0] diff;

  // Odd x gets P added first so the halving is exact; the carry needs the extra bit.
  always_comb begin
    sum   = {1'b0, x} + (x[0] ? {1'b0, P} : '0);
    half  = DAT_BITS'(sum >> 1);
    diff  = x - y + ((x < y) ? P : '0);
    res_c = sub ? diff : half;
  end

endmodule

// File: rtl/fe_inv_seq.sv
// Sequential modular divider: returns b * a^-1 mod P using binary extended
// Euclid, one reduction step per clock, one request in flight.
module fe_inv_seq #(
  parameter int unsigned         DAT_BITS = fe_inv_seq_pkg::DAT_BITS,
  parameter logic [DAT_BITS-1:0] P        = DAT_BITS'(fe_inv_seq_pkg::P),
  parameter int unsigned         MAX_ITER = 4 * DAT_BITS
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_val,
  output logic                              o_rdy,
  input  logic [DAT_BITS-1:0]               i_a,
  input  logic [DAT_BITS-1:0]               i_b,
  input  logic [7:0]                        i_tag,
  output logic                              o_val,
  input  logic                              i_rdy,
  output logic [DAT_BITS-1:0]               o_dat,
  output logic                              o_err,
  output logic [7:0]                        o_tag,
  output logic [$clog2(MAX_ITER+1)-1:0]     o_iter
);

  import fe_inv_seq_pkg::*;

  localparam int unsigned ITER_BITS = $clog2(MAX_ITER + 1);

  state_t state;
  state_t state_nxt;

  logic [DAT_BITS-1:0] u;
  logic [DAT_BITS-1:0] v;
  logic [DAT_BITS-1:0] x1;
  logic [DAT_BITS-1:0] x2;
  logic [DAT_BITS-1:0] x1_nxt;
  logic [DAT_BITS-1:0] x2_nxt;

  logic bad_a;
  logic u_one;
  logic term;
  logic limit;
  logic u_ge;
  logic load;
  logic fin_ok;
  logic fin_err;
  logic step;
  logic x1_upd;
  logic x2_upd;

  fe_half_sub #(.DAT_BITS(DAT_BITS), .P(P)) u_x1 (
    .x     (x1),
    .y     (x2),
    .sub   (u[0]),
    .res_c (x1_nxt)
  );

  fe_half_sub #(.DAT_BITS(DAT_BITS), .P(P)) u_x2 (
    .x     (x2),
    .y     (x1),
    .sub   (v[0]),
    .res_c (x2_nxt)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Termination is tested before the iteration limit, so a run may use all MAX_ITER steps.
  always_comb begin
    state_nxt = state;
    bad_a     = (i_a == '0) || (i_a >= P);
    u_one     = (u == DAT_BITS'(1));
    term      = u_one || (v == DAT_BITS'(1));
    limit     = (o_iter == ITER_BITS'(MAX_ITER));
    u_ge      = (u >= v);
    load      = 1'b0;
    fin_ok    = 1'b0;
    fin_err   = 1'b0;
    step      = 1'b0;
    x1_upd    = !u[0] || (v[0] && u_ge);
    x2_upd    = u[0] && (!v[0] || !u_ge);
    unique case (state)
      ST_IDLE: begin
        if (i_val) begin
          load      = 1'b1;
          state_nxt = bad_a ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (term) begin
          fin_ok    = 1'b1;
          state_nxt = ST_DONE;
        end else if (limit) begin
          fin_err   = 1'b1;
          state_nxt = ST_DONE;
        end else begin
          step = 1'b1;
        end
      end
      ST_DONE: begin
        if (i_rdy) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdy  <= 1'b1;
      o_val  <= 1'b0;
      o_err  <= 1'b0;
      o_dat  <= '0;
      o_tag  <= '0;
      o_iter <= '0;
      u      <= '0;
      v      <= '0;
      x1     <= '0;
      x2     <= '0;
    end else begin
      o_rdy <= (state_nxt == ST_IDLE);
      o_val <= (state_nxt == ST_DONE);
      if (load) begin
        u      <= i_a;
        v      <= P;
        x1     <= i_b;
        x2     <= '0;
        o_iter <= '0;
        o_tag  <= i_tag;
        o_err  <= bad_a;
        o_dat  <= '0;
      end else if (fin_ok) begin
        o_dat <= u_one ? x1 : x2;
        o_err <= 1'b0;
      end else if (fin_err) begin
        o_dat <= '0;
        o_err <= 1'b1;
      end else if (step) begin
        if (!u[0])      u <= u >> 1;
        else if (!v[0]) v <= v >> 1;
        else if (u_ge)  u <= u - v;
        else            v <= v - u;
        if (x1_upd) x1 <= x1_nxt;
        if (x2_upd) x2 <= x2_nxt;
        o_iter <= o_iter + ITER_BITS'(1);
      end
    end
  end

endmodule

// File: doc/fe_inv_seq.md
FE_INV_SEQ -- requirements
Module: fe_inv_seq

Interface
REQ-001 SHALL have parameter DAT_BITS, default 256, meaning the operand/result width.
REQ-002 SHALL have parameter P, default bn128 modulus, meaning the odd prime modulus; P < 2^DAT_BITS.
REQ-003 SHALL have parameter MAX_ITER, default 4*DAT_BITS, meaning the iteration limit before error.
REQ-004 SHALL have port i_clk, input, 1, the single clock.
REQ-005 SHALL have port i_rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port i_val, input, 1, request valid.
REQ-007 SHALL have port o_rdy, output, 1, ready to accept a request.
REQ-008 SHALL have port i_a, input, DAT_BITS, the divisor a.
REQ-009 SHALL have port i_b, input, DAT_BITS, the numerator b, required < P.
REQ-010 SHALL have port i_tag, input, 8, the request tag.
REQ-011 SHALL have port o_val, output, 1, result valid.
REQ-012 SHALL have port i_rdy, input, 1, downstream ready.
REQ-013 SHALL have port o_dat, output, DAT_BITS, the result b*a^-1 mod P.
REQ-014 SHALL have port o_err, output, 1, error: a==0, a>=P, or iteration limit reached.
REQ-015 SHALL have port o_tag, output, 8, the tag of the accepted request.
REQ-016 SHALL have port o_iter, output, clog2(MAX_ITER+1), the iterations used.

Function
REQ-017 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-018 SHALL assert o_rdy only in IDLE; a request is accepted on i_val & o_rdy.
REQ-019 On accept, SHALL load u=a, v=P, x1=b, x2=0, iter=0 and capture the tag.
- If a==0 or a>=P, SHALL go directly to DONE with o_err=1 and o_dat=0.
REQ-020 Each RUN cycle SHALL first test for termination: if u==1 or v==1, go to DONE with o_dat = (u==1 ? x1 : x2) and o_err=0.
REQ-021 Otherwise, each RUN cycle SHALL perform exactly one step, in this priority order:
- u even: u=u>>1; x1 = x1 even ? x1>>1 : (x1+P)>>1
- else v even: v=v>>1; x2 halved the same way
- else u>=v: u=u-v; x1=(x1-x2) mod P
- else: v=v-u; x2=(x2-x1) mod P
REQ-022 Halving SHALL use a DAT_BITS+1-bit intermediate; modular subtraction SHALL add P when the subtrahend is larger; x1 and x2 SHALL always stay < P.
REQ-023 SHALL increment iter once per step and go to DONE with o_err=1, o_dat=0 when iter reaches MAX_ITER without termination.
REQ-024 SHALL assert o_val in DONE and hold o_dat/o_err/o_tag/o_iter stable until i_val... SHALL hold them stable until i_rdy; the o_val & i_rdy cycle SHALL return the FSM to IDLE.
REQ-025 Latency SHALL be accept cycle + 1 + number of steps; for a==1, o_val rises 2 cycles after accept.
REQ-026 SHALL ignore i_val and all inputs outside IDLE; there SHALL be no pipelining (one request in flight).
REQ-027 SHALL never combinationally depend o_rdy on i_val, or o_val on i_rdy.

Reset
REQ-028 On i_rst, SHALL asynchronously enter IDLE with o_rdy=1 (after reset release), o_val=0, o_err=0, o_dat=0, o_tag=0, o_iter=0, u=v=x1=x2=0.
REQ-029 Reset mid-RUN or mid-DONE SHALL discard the operation; no o_val SHALL follow.

Structure
REQ-030 The P, DAT_BITS and fe_t typedef SHALL come from the shared curve package; a MAX_ITER default constant SHALL be added there.
REQ-031 A sub-module fe_half_sub SHALL implement the combined mod-P halve and mod-P subtract datapath, instantiated once per x register.
REQ-032 The block SHALL be bit-exact with the package fe_inv(a,b) function for all valid inputs.

Verification
REQ-033 Default P, a=1, b=1 -> o_dat=1, o_err=0, o_iter=0, o_val 2 cycles after accept.
REQ-034 Default P, a=2, b=1 -> o_dat=10944121435919637611123202872628637544348155578648911831344518947322613104292, o_err=0.
REQ-035 DAT_BITS=4, P=11: a=3, b=1 -> 4; a=3, b=5 -> 9; a=10, b=1 -> 10.
REQ-036 a=0 -> o_err=1, o_dat=0, o_val 1 cycle after accept; a=P -> o_err=1.
REQ-037 With i_rdy held low for 20 cycles after o_val, outputs SHALL stay stable and o_rdy=0; the bench then asserts reset during RUN and checks that o_val stays 0 and o_rdy=1 after release.
REQ-038 1000 random a in [1,P-1], b in [0,P-1] with random i_rdy backpressure -> o_dat matches fe_inv(a,b), o_iter <= MAX_ITER, o_err=0, and the tag is returned in order.
